input_conditioner: RTL
======================

# input_conditioner

Front-end block that turns raw panel inputs (hook/unhook buttons, write-mode button, 2-bit mode switch) into the clean control inputs consumed by the crane controller FSM: `hooked`, `unhooked`, `write_mode`, `mode_in`. It synchronises, debounces and edge-detects each input. Pulses are stretched so the FSM, which runs on the divided clock, cannot miss them. It sits between the board pins and the controller in the top level, clocked by the undivided `clk`.

## Interface
- `DEB_CYCLES`, default 16: consecutive stable cycles required to accept a new input level. Must be ≥ `PULSE_LEN` and ≥ 2.
- `PULSE_LEN`, default 2: length in `clk` cycles of `hooked` / `unhooked` pulses. Must be ≥ 2 (FSM runs at `clk`/2).
- `clk` in 1: system clock, undivided.
- `reset` in 1: synchronous, active-high reset.
- `btn_hook` in 1: raw hook button, asynchronous, active-high.
- `btn_unhook` in 1: raw unhook button, asynchronous, active-high.
- `btn_write` in 1: raw write-mode button, asynchronous, active-high.
- `sw_mode` in 2: raw mode switches, asynchronous.
- `hooked` out 1: `PULSE_LEN`-cycle pulse per accepted hook press.
- `unhooked` out 1: `PULSE_LEN`-cycle pulse per accepted unhook press.
- `write_mode` out 1: level; toggles on each accepted write press.
- `mode_in` out 2: debounced mode value; live only while `write_mode`=1.

## Operation
- **Sync stage**
  - Every raw input passes through a 2-flop synchroniser.
  - `sw_mode` is synchronised as a 2-bit bus.
- **Debounce**, one channel each for hook, unhook, write and the mode bus:
  - Each channel holds a stable value and a counter of width clog2(`DEB_CYCLES`).
  - When the synced value equals the stable value, the counter clears.
  - When they differ, the counter increments.
  - On the cycle the counter would reach `DEB_CYCLES`, the stable value takes the synced value and the counter clears.
  - For the mode bus, any change of the bus value during counting restarts the count from 0.
- **Hook/unhook pulse generator**
  - States: IDLE, PULSE_H, PULSE_U.
  - IDLE → PULSE_H on a stable-hook rising edge. IDLE → PULSE_U on a stable-unhook rising edge.
  - Both rising edges in the same cycle: both are dropped and the FSM stays in IDLE.
  - A pulse state holds its output high for exactly `PULSE_LEN` cycles, then returns to IDLE.
  - Rising edges that occur while in a pulse state are ignored, not queued.
- **write_mode**: inverts on each stable-write rising edge. Release edges have no effect.
- **mode_in**
  - Loads the stable mode bus every cycle while `write_mode`=1.
  - Holds its last value while `write_mode`=0.
  - On the cycle `write_mode` rises, `mode_in` first updates on the following cycle.
- **Reset**
  - All synchroniser flops, stable values, counters and the pulse FSM clear to 0 / IDLE.
  - Outputs clear: `hooked`=0, `unhooked`=0, `write_mode`=0, `mode_in`=2'b00.
  - Reset mid-pulse truncates the pulse on the next edge.
  - A button held through reset release is treated as a new press after debounce and produces a pulse.

## Timing
- All outputs are registered. No combinational path from input to output.
- Press latency: raw input high and steady from edge k → pulse output first high after edge k+`DEB_CYCLES`+3.
  - 2 cycles synchroniser.
  - `DEB_CYCLES` cycles debounce.
  - 1 cycle edge detect / FSM.
- `write_mode` toggle latency is the same as press latency.
- Mode switch latency to `mode_in` (with `write_mode`=1): `DEB_CYCLES`+3 edges.
- Glitches shorter than `DEB_CYCLES` cycles after synchronisation produce no output change.
- `hooked` and `unhooked` are never high in the same cycle.

## Configuration
- Macro: `INPUT_LOCKOUT_EN`.
  - **Defined:** in IDLE, hook/unhook edges are discarded while `write_mode`=1, so no crane motion is commanded during mode programming. A pulse already in progress when `write_mode` rises completes normally.
  - **Undefined:** hook/unhook pulses are generated regardless of `write_mode`.

## Test plan
All scenarios use `DEB_CYCLES`=4, `PULSE_LEN`=2.
- Reset with all inputs low → all outputs 0. Hold `reset` high for 3 cycles mid-pulse → `hooked` drops and stays 0.
- `btn_hook` high from edge 10 → `hooked` high on edges 17–18 only, low thereafter while the button is held.
- `btn_unhook` bouncing (1,0,1,0 for one cycle each), then steady high → no pulse until 4 stable cycles have passed, then exactly one 2-cycle `unhooked` pulse.
- `btn_hook` and `btn_unhook` rise on the same edge → neither output pulses. Hook alone 20 cycles later → normal `hooked` pulse.
- Press `btn_write` → `write_mode`=1. Set `sw_mode`=2'b10 → `mode_in`=2'b10 after 7 edges. Press `btn_write` → `write_mode`=0. Set `sw_mode`=2'b01 → `mode_in` stays 2'b10.
- With `INPUT_LOCKOUT_EN` defined and `write_mode`=1, press hook → `hooked` stays 0. Without the macro → 2-cycle pulse.

Source files
------------

// File: rtl/input_conditioner.sv
// Panel input front end: sync, debounce, edge detect, pulse stretch.
// Define INPUT_LOCKOUT_EN to suppress hook/unhook pulses while write_mode=1.

module ic_debounce #(
    parameter int W   = 1,
    parameter int DEB = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    localparam int CW = $clog2(DEB);
    localparam logic [CW-1:0] LAST = CW'(DEB - 1);

    logic [CW-1:0] cnt;
    logic [W-1:0]  prev;

    // prev lets a multi-bit bus restart its count when it moves mid-count
    always_ff @(posedge clk) begin
        if (reset) begin
            q    <= '0;
            cnt  <= '0;
            prev <= '0;
        end else begin
            prev <= d;
            if (d == q) begin
                cnt <= '0;
            end else if (d != prev && cnt != '0) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                q   <= d;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

module input_conditioner #(
    parameter int DEB_CYCLES = 16,
    parameter int PULSE_LEN  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_hook,
    input  logic       btn_unhook,
    input  logic       btn_write,
    input  logic [1:0] sw_mode,
    output logic       hooked,
    output logic       unhooked,
    output logic       write_mode,
    output logic [1:0] mode_in
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PULSE_H = 2'd1;
    localparam logic [1:0] PULSE_U = 2'd2;

    localparam int PW = $clog2(PULSE_LEN);
    localparam logic [PW-1:0] PLAST = PW'(PULSE_LEN - 1);

    logic [4:0]    s1;
    logic [4:0]    s2;
    logic          hook_s;
    logic          unhook_s;
    logic          write_s;
    logic [1:0]    mode_s;
    logic          hook_d;
    logic          unhook_d;
    logic          write_d;
    logic          rise_h;
    logic          rise_u;
    logic          rise_w;
    logic          go;
    logic [1:0]    state;
    logic [PW-1:0] pcnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= {sw_mode, btn_write, btn_unhook, btn_hook};
            s2 <= s1;
        end
    end

    ic_debounce #(.W(1), .DEB(DEB_CYCLES)) u_deb_h (
        .clk   (clk),
        .reset (reset),
        .d     (s2[0]),
        .q     (hook_s)
    );

    ic_debounce #(.W(1), .DEB(DEB_CYCLES)) u_deb_u (
        .clk   (clk),
        .reset (reset),
        .d     (s2[1]),
        .q     (unhook_s)
    );

    ic_debounce #(.W(1), .DEB(DEB_CYCLES)) u_deb_w (
        .clk   (clk),
        .reset (reset),
        .d     (s2[2]),
        .q     (write_s)
    );

    ic_debounce #(.W(2), .DEB(DEB_CYCLES)) u_deb_m (
        .clk   (clk),
        .reset (reset),
        .d     (s2[4:3]),
        .q     (mode_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            hook_d   <= 1'b0;
            unhook_d <= 1'b0;
            write_d  <= 1'b0;
        end else begin
            hook_d   <= hook_s;
            unhook_d <= unhook_s;
            write_d  <= write_s;
        end
    end

    assign rise_h = hook_s & ~hook_d;
    assign rise_u = unhook_s & ~unhook_d;
    assign rise_w = write_s & ~write_d;

`ifdef INPUT_LOCKOUT_EN
    assign go = ~write_mode;
`else
    assign go = 1'b1;
`endif

    // simultaneous hook and unhook edges cancel each other
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pcnt     <= '0;
            hooked   <= 1'b0;
            unhooked <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    pcnt <= '0;
                    if (go && rise_h && !rise_u) begin
                        state  <= PULSE_H;
                        hooked <= 1'b1;
                    end else if (go && rise_u && !rise_h) begin
                        state    <= PULSE_U;
                        unhooked <= 1'b1;
                    end
                end
                PULSE_H, PULSE_U: begin
                    if (pcnt == PLAST) begin
                        state    <= IDLE;
                        pcnt     <= '0;
                        hooked   <= 1'b0;
                        unhooked <= 1'b0;
                    end else begin
                        pcnt <= pcnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    pcnt     <= '0;
                    hooked   <= 1'b0;
                    unhooked <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_mode <= 1'b0;
            mode_in    <= 2'b00;
        end else begin
            write_mode <= write_mode ^ rise_w;
            if (write_mode) begin
                mode_in <= mode_s;
            end
        end
    end

endmodule
